// File: rtl/or_unit_rr_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit (OR/AND/XOR/NOR)
// among N requesters; three-state Moore FSM with a one-cycle ack/result_valid pulse.
module or_unit_rr_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_bus,
    input  logic [N*W-1:0]   b_bus,
    input  logic [2*N-1:0]   op_bus,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     ack,
    output logic [W-1:0]     result,
    output logic             result_valid,
    output logic             busy
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  gidx_q, gidx_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [1:0]     opc_q, opc_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [W-1:0]   result_q, result_d;
    logic           valid_q, valid_d;

    logic           found;
    logic [IW-1:0]  win_idx;
    int unsigned    scan_idx;

    // Scan from rr_ptr upward (mod N); the first asserted request wins.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % N;
            if (!found && req[IW'(scan_idx)]) begin
                found   = 1'b1;
                win_idx = IW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        opc_d    = opc_q;
        grant_d  = grant_q;
        ack_d    = '0;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (found) begin
                    opa_d            = a_bus[win_idx*W +: W];
                    opb_d            = b_bus[win_idx*W +: W];
                    opc_d            = op_bus[win_idx*2 +: 2];
                    gidx_d           = win_idx;
                    grant_d[win_idx] = 1'b1;
                    state_d          = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opc_q)
                    2'b00:   result_d = opa_q | opb_q;
                    2'b01:   result_d = opa_q & opb_q;
                    2'b10:   result_d = opa_q ^ opb_q;
                    default: result_d = ~(opa_q | opb_q);
                endcase
                ack_d   = grant_q;
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                grant_d  = '0;
                rr_ptr_d = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            opc_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            opc_q    <= opc_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign grant        = grant_q;
    assign ack          = ack_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign busy         = (state_q != S_IDLE);

endmodule
